mul_booth_sched: RTL and testbench

Shared-multiplier scheduler that arbitrates `REQ_NUM` requesters onto one iterative radix-4 Booth datapath. It accepts one signed multiply per grant using a valid/ready handshake. It sequences the datapath for `DATA_WIDTH/2` Booth steps, or fewer when early termination is compiled in. It returns the `2*DATA_WIDTH`-bit product tagged with the requester ID. It sits between the execute-stage requesters and the multiplier, so only one multiplier instance is needed per cluster.

---
 rtl/mul_booth_sched_pkg.sv | 25 ++
 rtl/mul_booth_sched_if.sv | 28 ++
 rtl/mul_02bit_booth.sv | 24 ++
 rtl/mul_booth_sched_rr_arb.sv | 30 +++
 rtl/mul_booth_sched.sv | 99 +++++++++
 tb/tb_mul_booth_sched.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mul_booth_sched_pkg.sv
// Shared types for the Booth multiplier scheduler: FSM states, radix-4 triplet codes
// and the step-count helper.
package mul_booth_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Radix-4 Booth triplets {y[i+1], y[i], y[i-1]}
  localparam logic [2:0] TRIP_Z0  = 3'b000;
  localparam logic [2:0] TRIP_P1A = 3'b001;
  localparam logic [2:0] TRIP_P1B = 3'b010;
  localparam logic [2:0] TRIP_P2  = 3'b011;
  localparam logic [2:0] TRIP_M2  = 3'b100;
  localparam logic [2:0] TRIP_M1A = 3'b101;
  localparam logic [2:0] TRIP_M1B = 3'b110;
  localparam logic [2:0] TRIP_Z1  = 3'b111;

  function automatic int unsigned booth_steps(input int unsigned w);
    return w / 2;
  endfunction

endpackage

// File: rtl/mul_booth_sched_if.sv
// Request/response bundle between the execute-stage requesters and the shared multiplier.
interface mul_booth_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4
);
  localparam int ID_WIDTH = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]                 i_req_vld;
  logic [REQ_NUM-1:0]                 o_req_rdy;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0] i_req_num_x;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0] i_req_num_y;
  logic                               o_rsp_vld;
  logic                               i_rsp_rdy;
  logic [ID_WIDTH-1:0]                o_rsp_id;
  logic [2*DATA_WIDTH-1:0]            o_rsp_res;
  logic                               o_busy;

  modport master (
    output i_req_vld, i_req_num_x, i_req_num_y, i_rsp_rdy,
    input  o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_res, o_busy
  );

  modport slave (
    input  i_req_vld, i_req_num_x, i_req_num_y, i_rsp_rdy,
    output o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_res, o_busy
  );

endinterface

// File: rtl/mul_02bit_booth.sv
// One radix-4 Booth partial product: maps a multiplier triplet onto 0, +-x or +-2x.
import mul_booth_sched_pkg::*;

module mul_02bit_booth #(
  parameter int W2 = 16
) (
  input  logic [W2-1:0] x,
  input  logic [2:0]    trip,
  output logic [W2-1:0] pp
);

  always_comb begin
    pp = '0;
    unique case (trip)
      TRIP_Z0, TRIP_Z1:   pp = '0;
      TRIP_P1A, TRIP_P1B: pp = x;
      TRIP_P2:            pp = x << 1;
      TRIP_M2:            pp = -(x << 1);
      TRIP_M1A, TRIP_M1B: pp = -x;
      default:            pp = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_sched_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module mul_booth_sched_rr_arb #(
  parameter int REQ_NUM  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [REQ_NUM-1:0]  vld,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [REQ_NUM-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx
);

  int j;

  // Walk the ring backwards so the closest valid entry to ptr is written last
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= REQ_NUM) j = j - REQ_NUM;
      if (vld[j]) begin
        gnt      = '0;
        gnt[j]   = 1'b1;
        gnt_idx  = ID_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/mul_booth_sched.sv
// Round-robin scheduler in front of one iterative radix-4 Booth multiplier.
// Optional MUL_BOOTH_SCHED_EARLY_END_EN ends CALC once the remaining multiplier bits are uniform.
import mul_booth_sched_pkg::*;

module mul_booth_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mul_booth_sched_if.slave  bus
);

  localparam int ID_WIDTH = $clog2(REQ_NUM);
  localparam int W2       = 2 * DATA_WIDTH;
  localparam int STEPS    = booth_steps(DATA_WIDTH);
  localparam int CW       = $clog2(STEPS + 1);

  state_e                  state, state_nxt;
  logic [W2-1:0]           x_r, acc, pp;
  logic [DATA_WIDTH:0]     y_r;
  logic [CW-1:0]           cnt;
  logic [ID_WIDTH-1:0]     id_r, ptr, gnt_idx;
  logic [REQ_NUM-1:0]      gnt;
  logic [DATA_WIDTH-1:0]   sel_x, sel_y;
  logic                    hs, last_step, skip;

  mul_booth_sched_rr_arb #(.REQ_NUM(REQ_NUM), .ID_WIDTH(ID_WIDTH)) u_arb (
    .vld     (bus.i_req_vld),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  mul_02bit_booth #(.W2(W2)) u_booth (
    .x    (x_r),
    .trip (y_r[2:0]),
    .pp   (pp)
  );

  assign sel_x     = bus.i_req_num_x[gnt_idx];
  assign sel_y     = bus.i_req_num_y[gnt_idx];
  assign hs        = (state == ST_IDLE) && (|gnt);
  assign last_step = (cnt == CW'(STEPS - 1));

`ifdef MUL_BOOTH_SCHED_EARLY_END_EN
  // y_r is shifted logically, so only its low (W+1-2*cnt) bits are still live
  logic [DATA_WIDTH:0] rem_mask, y_rem;
  assign rem_mask = {(DATA_WIDTH+1){1'b1}} >> {cnt, 1'b0};
  assign y_rem    = y_r & rem_mask;
  assign skip     = (y_rem == '0) || (y_rem == rem_mask);
`else
  assign skip     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (hs) state_nxt = ST_CALC;
      ST_CALC: if (skip || last_step) state_nxt = ST_DONE;
      ST_DONE: if (bus.i_rsp_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      id_r  <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        x_r  <= {{DATA_WIDTH{sel_x[DATA_WIDTH-1]}}, sel_x};
        y_r  <= {sel_y, 1'b0};
        id_r <= gnt_idx;
        acc  <= '0;
        cnt  <= '0;
        ptr  <= (gnt_idx == ID_WIDTH'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state == ST_CALC && !skip) begin
        acc <= acc + pp;
        x_r <= x_r << 2;
        y_r <= y_r >> 2;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.o_req_rdy = (state == ST_IDLE) ? gnt : '0;
  assign bus.o_rsp_vld = (state == ST_DONE);
  assign bus.o_rsp_res = acc;
  assign bus.o_rsp_id  = id_r;
  assign bus.o_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_booth_sched.sv
// Directed bench for mul_booth_sched with a per-cycle behavioural model and literal expectations.
module tb_mul_booth_sched;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int STEPS = W / 2;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  mul_booth_sched_if #(.DATA_WIDTH(W), .REQ_NUM(N)) bus ();

  mul_booth_sched #(.DATA_WIDTH(W), .REQ_NUM(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] a, b;
    a = $signed(x);
    b = $signed(y);
    return a * b;
  endfunction

  // Cycles from handshake to first o_rsp_vld
  function automatic int exp_lat(input logic [W-1:0] y);
`ifdef MUL_BOOTH_SCHED_EARLY_END_EN
    logic signed [W-1:0] ys;
    int v;
    ys = y;
    v  = int'(ys);
    if (v == 0) return 2;
    // k steps suffice once y is representable as a signed 2k-bit value
    for (int k = 1; k < STEPS; k++)
      if (v >= -(1 << (2*k-1)) && v < (1 << (2*k-1))) return k + 2;
    return STEPS + 1;
`else
    return STEPS + 1;
`endif
  endfunction

  // ---------------- model + compare ----------------
  bit              busy_m   = 1'b0;
  bit              rst_seen = 1'b0;
  int              mptr     = 0;
  int              p_id     = 0;
  int              p_due    = 0;
  logic [2*W-1:0]  p_res    = '0;
  int              glog[$];

  always @(negedge i_clk) begin
    logic [N-1:0] erdy;
    int g, j;
    if (!i_rst_n) begin
      busy_m   = 1'b0;
      mptr     = 0;
      rst_seen = 1'b1;
    end else begin
      erdy = '0;
      g    = -1;
      if (!busy_m)
        for (int i = 0; i < N; i++) begin
          j = (mptr + i) % N;
          if (g < 0 && bus.i_req_vld[j]) g = j;
        end
      if (g >= 0) erdy[g] = 1'b1;
      chk("req_rdy", 32'(bus.o_req_rdy), 32'(erdy));
      chk("busy", 32'(bus.o_busy), 32'(busy_m));
      chk("rsp_vld", 32'(bus.o_rsp_vld), 32'(busy_m && cyc >= p_due));
      if (rst_seen) begin
        chk("rst_res", 32'(bus.o_rsp_res), 0);
        chk("rst_id", 32'(bus.o_rsp_id), 0);
        rst_seen = 1'b0;
      end
      if (busy_m && cyc >= p_due && bus.o_rsp_vld) begin
        chk("rsp_res", 32'(bus.o_rsp_res), 32'(p_res));
        chk("rsp_id", 32'(bus.o_rsp_id), 32'(p_id));
        if (bus.i_rsp_rdy) busy_m = 1'b0;
      end else if (g >= 0) begin
        p_id   = g;
        p_res  = exp_prod(bus.i_req_num_x[g], bus.i_req_num_y[g]);
        p_due  = cyc + exp_lat(bus.i_req_num_y[g]);
        busy_m = 1'b1;
        mptr   = (g + 1) % N;
        glog.push_back(g);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_op(input int r, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.i_req_num_x[r] = x;
    bus.i_req_num_y[r] = y;
  endtask

  // Keeps requests up until granted, then waits for the block to go idle
  task automatic drain(input int bound);
    int n;
    logic [N-1:0] hs;
    n = 0;
    while ((bus.i_req_vld != '0 || bus.o_busy) && n < bound) begin
      @(negedge i_clk);
      hs = bus.i_req_vld & bus.o_req_rdy;
      @(posedge i_clk); #1;
      bus.i_req_vld = bus.i_req_vld & ~hs;
      n++;
    end
    chk("drain_timeout", 32'(n < bound), 1);
  endtask

  task automatic single(input string nm, input int r, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] eres, input int elat);
    int t0, t1, n;
    set_op(r, x, y);
    bus.i_req_vld[r] = 1'b1;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!bus.o_req_rdy[r] && n < 50);
    t0 = cyc;
    @(posedge i_clk); #1;
    bus.i_req_vld[r] = 1'b0;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!bus.o_rsp_vld && n < 50);
    t1 = cyc;
    chk({nm, "_lat"}, 32'(t1 - t0), 32'(elat));
    chk({nm, "_res"}, 32'(bus.o_rsp_res), 32'(eres));
    chk({nm, "_id"}, 32'(bus.o_rsp_id), 32'(r));
    @(posedge i_clk); #1;
  endtask

  typedef struct { int r; logic [W-1:0] x; logic [W-1:0] y; } vec_t;
  vec_t vecs[6] = '{'{1, 8'h12, 8'h34}, '{2, 8'h81, 8'h7F}, '{3, 8'hC3, 8'h05},
                    '{0, 8'h40, 8'hFE}, '{1, 8'h01, 8'h80}, '{2, 8'hAA, 8'h03}};

  initial begin
    int n;
    bus.i_req_vld   = '0;
    bus.i_req_num_x = '0;
    bus.i_req_num_y = '0;
    bus.i_rsp_rdy   = 1'b1;
    // Round robin: all four valid coming out of reset
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 2), 8'(7 - i));
    bus.i_req_vld = '1;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    drain(200);
    chk("rr_cnt", 32'(glog.size()), 4);
    if (glog.size() == 4)
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(glog[i]), 32'(i));
    glog.delete();
    set_op(0, 8'h09, 8'hF7);
    set_op(2, 8'hE0, 8'h11);
    bus.i_req_vld = 4'b0101;
    drain(200);
    chk("rr_wrap_cnt", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("rr_wrap_first", 32'(glog[0]), 0);
      chk("rr_wrap_second", 32'(glog[1]), 2);
    end

    // Basic and corner operands
`ifdef MUL_BOOTH_SCHED_EARLY_END_EN
    single("basic",  0, 8'h03, 8'h05, 16'h000F, 4);
    single("ff_ff",  3, 8'hFF, 8'hFF, 16'h0001, 3);
    single("ee_y0",  1, 8'h07, 8'h00, 16'h0000, 2);
    single("ee_yff", 2, 8'h05, 8'hFF, 16'hFFFB, 3);
`else
    single("basic",  0, 8'h03, 8'h05, 16'h000F, 5);
    single("ff_ff",  3, 8'hFF, 8'hFF, 16'h0001, 5);
    single("ee_y0",  1, 8'h07, 8'h00, 16'h0000, 5);
    single("ee_yff", 2, 8'h05, 8'hFF, 16'hFFFB, 5);
`endif
    single("min_min", 1, 8'h80, 8'h80, 16'h4000, 5);
    single("max_min", 2, 8'h7F, 8'h80, 16'hC080, 5);
    single("max_max", 0, 8'h7F, 8'h7F, 16'h3F01, 5);
    foreach (vecs[i])
      single("vec", vecs[i].r, vecs[i].x, vecs[i].y, exp_prod(vecs[i].x, vecs[i].y), exp_lat(vecs[i].y));

    // Backpressure: hold DONE for 10 cycles with another requester waiting
    bus.i_rsp_rdy = 1'b0;
    set_op(1, 8'h0B, 8'hF3);
    bus.i_req_vld[1] = 1'b1;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!bus.o_req_rdy[1] && n < 50);
    @(posedge i_clk); #1;
    bus.i_req_vld[1] = 1'b0;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!bus.o_rsp_vld && n < 50);
    @(posedge i_clk); #1;
    set_op(3, 8'h02, 8'h03);
    bus.i_req_vld[3] = 1'b1;
    repeat (10) begin
      @(negedge i_clk);
      chk("bp_vld", 32'(bus.o_rsp_vld), 1);
      chk("bp_res", 32'(bus.o_rsp_res), 32'h0000FF71);
      chk("bp_id", 32'(bus.o_rsp_id), 1);
      chk("bp_rdy", 32'(bus.o_req_rdy), 0);
    end
    @(posedge i_clk); #1;
    bus.i_rsp_rdy = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("bp_idle_busy", 32'(bus.o_busy), 0);
    chk("bp_idle_rdy", 32'(bus.o_req_rdy), 32'b1000);
    @(posedge i_clk); #1;
    bus.i_req_vld[3] = 1'b0;
    drain(50);

    // Reset during the second CALC cycle
    set_op(2, 8'h33, 8'h44);
    bus.i_req_vld[2] = 1'b1;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!bus.o_req_rdy[2] && n < 50);
    @(posedge i_clk); #1;
    bus.i_req_vld[2] = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_rdy", 32'(bus.o_req_rdy), 0);
    repeat (8) begin
      @(negedge i_clk);
      chk("rst_no_rsp", 32'(bus.o_rsp_vld), 0);
    end
    single("post_rst", 2, 8'hF0, 8'h10, 16'hFF00, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
